// File: rtl/serial_pattern_tx_if.sv
// Serial pattern transmitter port bundle: command side (load/start/stop) plus the serial line and status.
// master is the transmitter that drives the line; slave is the controlling/observing side.
interface serial_pattern_tx_if #(
    parameter int WIDTH = 16,
    parameter int LEN_W = 5
);
    logic             load;
    logic [WIDTH-1:0] data_in;
    logic [LEN_W-1:0] length;
    logic             start;
    logic             repeat_en;
    logic             stop;
    logic             serial_out;
    logic             bit_valid;
    logic             busy;
    logic             done;
    logic [LEN_W-1:0] bit_index;
    logic             expect_101;

    modport master (
        input  load, data_in, length, start, repeat_en, stop,
        output serial_out, bit_valid, busy, done, bit_index, expect_101
    );

    modport slave (
        output load, data_in, length, start, repeat_en, stop,
        input  serial_out, bit_valid, busy, done, bit_index, expect_101
    );
endinterface

// File: rtl/serial_pattern_tx.sv
// Bit-serial pattern transmitter: shifts a loaded word out LSB-first with optional repeat and a 1-0-1 reference flag.
// Latency: start sampled at edge N puts bit 0 on the line after edge N; one bit per clock, done one cycle after the last bit.
// Backpressure: none on the line; load/start are ignored while busy, stop aborts on the next edge.
module serial_pattern_tx #(
    parameter int WIDTH = 16,
    parameter int LEN_W = 5
) (
    input  logic                clock,
    input  logic                reset,
    serial_pattern_tx_if.master bus
);
    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    // The length register holds the index of the final bit, so WIDTH=32 still fits in LEN_W bits.
    localparam logic [LEN_W-1:0] FULL_LAST = LEN_W'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] data_reg, data_nxt;
    logic [LEN_W-1:0] last_reg, last_nxt;
    logic             serial_out_q, serial_out_nxt;
    logic             bit_valid_q, bit_valid_nxt;
    logic             busy_q, busy_nxt;
    logic             done_q, done_nxt;
    logic [LEN_W-1:0] bit_index_q, bit_index_nxt;
    logic [1:0]       hist_q, hist_nxt;
    logic [LEN_W-1:0] load_last;
    logic [WIDTH-1:0] send_data;
    logic [WIDTH-1:0] shifted;
    logic             at_last;

    always_comb begin
        if (bus.length == '0 || int'(bus.length) > WIDTH)
            load_last = FULL_LAST;
        else
            load_last = bus.length - LEN_W'(1);
    end

    // A load in the same cycle as start must feed the first bit directly.
    assign send_data = bus.load ? bus.data_in : data_reg;
    assign at_last   = (bit_index_q == last_reg);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            data_reg     <= '0;
            last_reg     <= FULL_LAST;
            serial_out_q <= 1'b0;
            bit_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            bit_index_q  <= '0;
            hist_q       <= 2'b00;
        end else begin
            state        <= state_nxt;
            data_reg     <= data_nxt;
            last_reg     <= last_nxt;
            serial_out_q <= serial_out_nxt;
            bit_valid_q  <= bit_valid_nxt;
            busy_q       <= busy_nxt;
            done_q       <= done_nxt;
            bit_index_q  <= bit_index_nxt;
            hist_q       <= hist_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.start) state_nxt = SEND;
            SEND: begin
                if (bus.stop)
                    state_nxt = IDLE;
                else if (at_last && !bus.repeat_en)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        data_nxt       = data_reg;
        last_nxt       = last_reg;
        serial_out_nxt = serial_out_q;
        bit_valid_nxt  = bit_valid_q;
        busy_nxt       = busy_q;
        done_nxt       = 1'b0;
        bit_index_nxt  = bit_index_q;
        hist_nxt       = hist_q;
        shifted        = '0;
        case (state)
            IDLE: begin
                if (bus.load) begin
                    data_nxt = bus.data_in;
                    last_nxt = load_last;
                end
                if (bus.start) begin
                    serial_out_nxt = send_data[0];
                    bit_valid_nxt  = 1'b1;
                    busy_nxt       = 1'b1;
                    bit_index_nxt  = '0;
                    hist_nxt       = 2'b00;
                end
            end
            SEND: begin
                hist_nxt = {hist_q[0], serial_out_q};
                if (bus.stop) begin
                    serial_out_nxt = 1'b0;
                    bit_valid_nxt  = 1'b0;
                    busy_nxt       = 1'b0;
                    bit_index_nxt  = '0;
                end else if (at_last) begin
                    done_nxt      = 1'b1;
                    bit_index_nxt = '0;
                    if (bus.repeat_en) begin
                        serial_out_nxt = data_reg[0];
                    end else begin
                        serial_out_nxt = 1'b0;
                        bit_valid_nxt  = 1'b0;
                        busy_nxt       = 1'b0;
                    end
                end else begin
                    bit_index_nxt  = bit_index_q + LEN_W'(1);
                    shifted        = data_reg >> bit_index_nxt;
                    serial_out_nxt = shifted[0];
                end
            end
            default: ;
        endcase
    end

    assign bus.serial_out = serial_out_q;
    assign bus.bit_valid  = bit_valid_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.bit_index  = bit_index_q;
    assign bus.expect_101 = bit_valid_q & serial_out_q & hist_q[1] & ~hist_q[0];
endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed bench for serial_pattern_tx: fixed patterns with hand-computed line bits, indices, done and 1-0-1 flags.
module tb_serial_pattern_tx;
    localparam int WIDTH = 16;
    localparam int LEN_W = 5;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    serial_pattern_tx_if #(.WIDTH(WIDTH), .LEN_W(LEN_W)) bus ();

    serial_pattern_tx #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic idle_inputs();
        bus.load      = 1'b0;
        bus.start     = 1'b0;
        bus.stop      = 1'b0;
        bus.repeat_en = 1'b0;
        bus.data_in   = '0;
        bus.length    = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.serial_out, bus.bit_valid, bus.busy, bus.done, bus.expect_101} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_flags got=%b want=00000",
                     {bus.serial_out, bus.bit_valid, bus.busy, bus.done, bus.expect_101});
        end
        checks++;
        if (bus.bit_index !== 5'd0) begin
            errors++;
            $display("FAIL reset_index got=%0d want=0", bus.bit_index);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            errors++;
            $display("FAIL reset_release got=%b want=00", {bus.busy, bus.done});
        end
    endtask

    task automatic test_basic();
        logic [15:0] line = 16'b0100_1010_0101_1011;
        logic [15:0] m101 = 16'b0000_1000_0100_1000;
        bus.data_in = 16'b0100_1010_0101_1011;
        bus.length  = 5'd16;
        bus.load    = 1'b1;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.load  = 1'b0;
        bus.start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if ({bus.serial_out, bus.bit_index, bus.bit_valid, bus.busy, bus.done} !==
                {line[0], LEN_W'(i), 3'b110}) begin
                errors++;
                $display("FAIL basic_bit i=%0d got=%b want=%b", i,
                         {bus.serial_out, bus.bit_index, bus.bit_valid, bus.busy, bus.done},
                         {line[0], LEN_W'(i), 3'b110});
            end
            checks++;
            if (bus.expect_101 !== m101[0]) begin
                errors++;
                $display("FAIL basic_101 i=%0d got=%b want=%b", i, bus.expect_101, m101[0]);
            end
            line = line >> 1;
            m101 = m101 >> 1;
            @(negedge clk);
        end
        checks++;
        if ({bus.done, bus.busy, bus.bit_valid, bus.serial_out, bus.bit_index} !== {4'b1000, 5'd0}) begin
            errors++;
            $display("FAIL basic_end got=%b want=100000000",
                     {bus.done, bus.busy, bus.bit_valid, bus.serial_out, bus.bit_index});
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_pulse got=%b want=0", bus.done);
        end
    endtask

    task automatic test_repeat();
        logic exp_bit, exp_done, exp_e;
        bus.data_in   = 16'h0005;
        bus.length    = 5'd3;
        bus.repeat_en = 1'b1;
        bus.load      = 1'b1;
        bus.start     = 1'b1;
        @(negedge clk);
        bus.load  = 1'b0;
        bus.start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            exp_bit  = (i % 3) != 1;
            exp_done = (i == 3) || (i == 6);
            exp_e    = (i % 3) == 2;
            checks++;
            if ({bus.serial_out, bus.bit_index, bus.bit_valid, bus.busy, bus.done, bus.expect_101} !==
                {exp_bit, LEN_W'(i % 3), 2'b11, exp_done, exp_e}) begin
                errors++;
                $display("FAIL repeat_bit i=%0d got=%b want=%b", i,
                         {bus.serial_out, bus.bit_index, bus.bit_valid, bus.busy, bus.done, bus.expect_101},
                         {exp_bit, LEN_W'(i % 3), 2'b11, exp_done, exp_e});
            end
            if (i == 8) bus.repeat_en = 1'b0;
            @(negedge clk);
        end
        checks++;
        if ({bus.done, bus.busy, bus.bit_valid} !== 3'b100) begin
            errors++;
            $display("FAIL repeat_end got=%b want=100", {bus.done, bus.busy, bus.bit_valid});
        end
        @(negedge clk);
    endtask

    task automatic test_ignore_busy();
        logic [15:0] line = 16'hC3A5;
        bus.data_in = 16'hC3A5;
        bus.length  = 5'd16;
        bus.load    = 1'b1;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.load  = 1'b0;
        bus.start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if ({bus.serial_out, bus.bit_index, bus.bit_valid, bus.busy, bus.done} !==
                {line[0], LEN_W'(i), 3'b110}) begin
                errors++;
                $display("FAIL ignore_bit i=%0d got=%b want=%b", i,
                         {bus.serial_out, bus.bit_index, bus.bit_valid, bus.busy, bus.done},
                         {line[0], LEN_W'(i), 3'b110});
            end
            line = line >> 1;
            if (i == 5) begin
                bus.data_in = 16'hFFFF;
                bus.length  = 5'd4;
                bus.load    = 1'b1;
                bus.start   = 1'b1;
            end else begin
                bus.load  = 1'b0;
                bus.start = 1'b0;
            end
            @(negedge clk);
        end
        checks++;
        if ({bus.done, bus.busy} !== 2'b10) begin
            errors++;
            $display("FAIL ignore_end got=%b want=10", {bus.done, bus.busy});
        end
        @(negedge clk);
        checks++;
        if ({bus.done, bus.busy} !== 2'b00) begin
            errors++;
            $display("FAIL ignore_after got=%b want=00", {bus.done, bus.busy});
        end
    endtask

    task automatic test_stop();
        logic [15:0] line = 16'h5A96;
        bus.data_in = 16'h5A96;
        bus.length  = 5'd16;
        bus.load    = 1'b1;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.load  = 1'b0;
        bus.start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if ({bus.serial_out, bus.bit_index, bus.busy} !== {line[0], LEN_W'(i), 1'b1}) begin
                errors++;
                $display("FAIL stop_pre i=%0d got=%b want=%b", i,
                         {bus.serial_out, bus.bit_index, bus.busy}, {line[0], LEN_W'(i), 1'b1});
            end
            line = line >> 1;
            if (i == 7) bus.stop = 1'b1;
            @(negedge clk);
        end
        bus.stop = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({bus.serial_out, bus.bit_valid, bus.busy, bus.done} !== 4'b0000) begin
                errors++;
                $display("FAIL stop_idle c=%0d got=%b want=0000", i,
                         {bus.serial_out, bus.bit_valid, bus.busy, bus.done});
            end
            @(negedge clk);
        end
        line      = 16'h5A96;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if ({bus.serial_out, bus.bit_index, bus.bit_valid, bus.busy, bus.done} !==
                {line[0], LEN_W'(i), 3'b110}) begin
                errors++;
                $display("FAIL stop_resend i=%0d got=%b want=%b", i,
                         {bus.serial_out, bus.bit_index, bus.bit_valid, bus.busy, bus.done},
                         {line[0], LEN_W'(i), 3'b110});
            end
            line = line >> 1;
            @(negedge clk);
        end
        checks++;
        if ({bus.done, bus.busy} !== 2'b10) begin
            errors++;
            $display("FAIL stop_resend_end got=%b want=10", {bus.done, bus.busy});
        end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        bus.data_in = 16'hFFFF;
        bus.length  = 5'd5;
        bus.load    = 1'b1;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.load  = 1'b0;
        bus.start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({bus.serial_out, bus.bit_index, bus.busy} !== {1'b1, LEN_W'(i), 1'b1}) begin
                errors++;
                $display("FAIL areset_pre i=%0d got=%b want=%b", i,
                         {bus.serial_out, bus.bit_index, bus.busy}, {1'b1, LEN_W'(i), 1'b1});
            end
            if (i < 4) @(negedge clk);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.serial_out, bus.bit_valid, bus.busy, bus.done, bus.expect_101, bus.bit_index} !== 10'd0) begin
            errors++;
            $display("FAIL areset_now got=%b want=0000000000",
                     {bus.serial_out, bus.bit_valid, bus.busy, bus.done, bus.expect_101, bus.bit_index});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.done, bus.busy} !== 2'b00) begin
            errors++;
            $display("FAIL areset_no_done got=%b want=00", {bus.done, bus.busy});
        end
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if ({bus.serial_out, bus.bit_index, bus.bit_valid, bus.busy, bus.done} !==
                {1'b0, LEN_W'(i), 3'b110}) begin
                errors++;
                $display("FAIL areset_default i=%0d got=%b want=%b", i,
                         {bus.serial_out, bus.bit_index, bus.bit_valid, bus.busy, bus.done},
                         {1'b0, LEN_W'(i), 3'b110});
            end
            @(negedge clk);
        end
        checks++;
        if ({bus.done, bus.busy} !== 2'b10) begin
            errors++;
            $display("FAIL areset_default_end got=%b want=10", {bus.done, bus.busy});
        end
        @(negedge clk);
    endtask

    task automatic test_length_clamp();
        logic [15:0] line;
        for (int k = 0; k < 2; k++) begin
            line        = 16'h8001;
            bus.data_in = 16'h8001;
            bus.length  = (k == 0) ? LEN_W'(0) : LEN_W'(20);
            bus.load    = 1'b1;
            bus.start   = 1'b1;
            @(negedge clk);
            bus.load  = 1'b0;
            bus.start = 1'b0;
            for (int i = 0; i < 16; i++) begin
                checks++;
                if ({bus.serial_out, bus.bit_index, bus.bit_valid, bus.busy, bus.done} !==
                    {line[0], LEN_W'(i), 3'b110}) begin
                    errors++;
                    $display("FAIL clamp_bit k=%0d i=%0d got=%b want=%b", k, i,
                             {bus.serial_out, bus.bit_index, bus.bit_valid, bus.busy, bus.done},
                             {line[0], LEN_W'(i), 3'b110});
                end
                line = line >> 1;
                @(negedge clk);
            end
            checks++;
            if ({bus.done, bus.busy, bus.bit_valid} !== 3'b100) begin
                errors++;
                $display("FAIL clamp_end k=%0d got=%b want=100", k, {bus.done, bus.busy, bus.bit_valid});
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_repeat();
        test_ignore_busy();
        test_stop();
        test_async_reset();
        test_length_clamp();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
